// File: rtl/tg_pkg.sv
// Shared constants and types for the task-generator push arbiter.
package tg_pkg;

  function automatic int tree_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TREE_NUM_BITS = tree_bits(5);
  localparam int PTW           = 16;
  localparam int MTW           = $clog2(5);

  typedef struct packed {
    logic [TREE_NUM_BITS-1:0] tree_id;
    logic [PTW-1:0]           prio;
    logic [MTW+PTW-1:0]       data;
  } push_req_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tg_rr_arb.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module tg_rr_arb #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PW'((int'(idx) + 1) % N);
      end
    end
  end

endmodule

// File: rtl/tg_push_arbiter.sv
// Round-robin ingress arbiter with credit tracking feeding the task generator push port.
// Optional per-tree push statistics enabled by defining TG_PUSH_ARB_STATS_EN.
module tg_push_arbiter #(
  parameter  int NUM_SRC       = 4,
  parameter  int TREE_NUM      = 5,
  parameter  int PTW           = 16,
  parameter  int MTW           = $clog2(TREE_NUM),
  parameter  int FIFO_SIZE     = 2048,
`ifdef TG_PUSH_ARB_STATS_EN
  parameter  int CNT_W         = 32,
`endif
  parameter  int TREE_NUM_BITS = tg_pkg::tree_bits(TREE_NUM),
  localparam int DW            = MTW + PTW,
  localparam int CW            = $clog2(FIFO_SIZE + 1)
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic [NUM_SRC-1:0]           i_src_valid,
  output logic [NUM_SRC-1:0]           o_src_ready,
  input  logic [NUM_SRC*TREE_NUM_BITS-1:0] i_src_tree_id,
  input  logic [NUM_SRC*PTW-1:0]       i_src_priority,
  input  logic [NUM_SRC*DW-1:0]        i_src_data,
  input  logic                         i_task_fifo_full,
  input  logic                         i_credit_return,
  input  logic                         i_push_inhibit,
  output logic                         o_push,
  output logic [TREE_NUM_BITS-1:0]     o_push_tree_id,
  output logic [PTW-1:0]               o_push_priority,
  output logic [DW-1:0]                o_push_data,
  output logic [CW-1:0]                o_credit,
  output logic [15:0]                  o_drop_cnt,
`ifdef TG_PUSH_ARB_STATS_EN
  output logic [TREE_NUM*CNT_W-1:0]    o_tree_push_cnt,
`endif
  output logic                         o_credit_err
);

  import tg_pkg::*;

  localparam int            PW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CW-1:0] FULL_CREDIT = CW'(FIFO_SIZE);

  typedef struct packed {
    logic [TREE_NUM_BITS-1:0] tree_id;
    logic [PTW-1:0]           prio;
    logic [DW-1:0]            data;
  } req_t;

  arb_state_e          state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       ptr_nxt;
  logic [CW-1:0]       credit_q;
  logic [CW-1:0]       credit_nxt;
  logic [NUM_SRC-1:0]  req_vec;
  logic [NUM_SRC-1:0]  grant;
  logic                can_grant;
  logic                xfer;
  logic                bad_xfer;
  logic                good_xfer;
  logic                ret_at_full;
  req_t                sel;
  req_t                push_r;
  logic                push_q;
  logic [15:0]         drop_q;
  logic                err_q;

  assign can_grant = (state_q == RUN) && !i_push_inhibit && !i_task_fifo_full &&
                     (credit_q != '0);
  assign req_vec   = can_grant ? i_src_valid : '0;

  tg_rr_arb #(.N(NUM_SRC)) u_rr_arb (
    .req      (req_vec),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (ptr_nxt)
  );

  assign o_src_ready = grant;
  assign xfer        = |grant;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel.tree_id = i_src_tree_id[i*TREE_NUM_BITS +: TREE_NUM_BITS];
        sel.prio    = i_src_priority[i*PTW +: PTW];
        sel.data    = i_src_data[i*DW +: DW];
      end
    end
  end

  // Out-of-range trees are consumed from the source but never reach the FIFO.
  assign bad_xfer    = xfer && ({1'b0, sel.tree_id} >= (TREE_NUM_BITS+1)'(TREE_NUM));
  assign good_xfer   = xfer && !bad_xfer;
  assign ret_at_full = i_credit_return && !good_xfer && (credit_q == FULL_CREDIT);

  always_comb begin
    credit_nxt = credit_q;
    if (good_xfer && !i_credit_return) begin
      credit_nxt = credit_q - CW'(1);
    end else if (!good_xfer && i_credit_return && !ret_at_full) begin
      credit_nxt = credit_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if ((credit_nxt == '0) || i_task_fifo_full) state_q <= STALL;
        STALL:   if ((credit_q != '0) && !i_task_fifo_full)  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr_q    <= '0;
      credit_q <= FULL_CREDIT;
      err_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (xfer) ptr_q <= ptr_nxt;
      credit_q <= credit_nxt;
      if (ret_at_full) err_q <= 1'b1;
      if (bad_xfer && (drop_q != '1)) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      push_q <= 1'b0;
      push_r <= '0;
    end else begin
      push_q <= good_xfer;
      if (good_xfer) push_r <= sel;
    end
  end

  assign o_push          = push_q;
  assign o_push_tree_id  = push_r.tree_id;
  assign o_push_priority = push_r.prio;
  assign o_push_data     = push_r.data;
  assign o_credit        = credit_q;
  assign o_drop_cnt      = drop_q;
  assign o_credit_err    = err_q;

`ifdef TG_PUSH_ARB_STATS_EN
  logic [TREE_NUM*CNT_W-1:0] tree_cnt_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tree_cnt_q <= '0;
    end else if (push_q) begin
      for (int unsigned t = 0; t < TREE_NUM; t++) begin
        if (push_r.tree_id == TREE_NUM_BITS'(t)) begin
          tree_cnt_q[t*CNT_W +: CNT_W] <= tree_cnt_q[t*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign o_tree_push_cnt = tree_cnt_q;
`endif

endmodule
